// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter fed by a word FIFO; back-to-back framing with
//               optional parity and, with UART_TX_STOP2_EN, two stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic                     we,
    input  logic [7:0]               data,
    input  logic                     bit8,
    input  logic                     parity_en,
    input  logic                     odd_n_even,
    input  logic                     stop2,
    input  logic [DIV_W-1:0]         divisor,
    input  logic                     ovf_clr,
    output logic                     txrdy,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int                c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full   = (c_addr_w + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4
`ifdef UART_TX_STOP2_EN
        , ST_STOP2 = 3'd5
`endif
    } state_t;

    logic [7:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                r_overflow;

    state_t              r_state, w_state_next;
    logic [DIV_W-1:0]    r_baud, w_baud_next, w_div_m1;
    logic [2:0]          r_bit_idx, w_idx_next;
    logic [7:0]          r_shift, w_shift_next;
    logic                r_tx, w_tx_next;
    logic                r_bit8, r_par_en, r_parity;
`ifdef UART_TX_STOP2_EN
    logic                r_stop2;
`else
    logic                w_unused_stop2;
    assign w_unused_stop2 = stop2;
`endif

    logic       w_full, w_empty, w_push, w_drop, w_pop, w_bit_end, w_frame_done;
    logic [7:0] w_head, w_head_bits;
    logic       w_par;

    assign w_full      = (r_count == c_full);
    assign w_empty     = (r_count == '0);
    assign w_push      = cs & we & ~w_full;
    assign w_drop      = cs & we & w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_bits = bit8 ? w_head : {1'b0, w_head[6:0]};
    assign w_par       = odd_n_even ^ (^w_head_bits);
    assign w_div_m1    = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign w_bit_end   = (r_baud == '0);

    assign txrdy      = ~w_full;
    assign tx         = r_tx;
    assign busy       = (r_state != ST_IDLE);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = w_bit_end ? w_div_m1 : r_baud - DIV_W'(1);
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_frame_done = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = r_baud;
                w_pop       = ~w_empty;
            end
            ST_START: if (w_bit_end) begin
                w_state_next = ST_DATA;
                w_idx_next   = 3'd0;
            end
            ST_DATA: if (w_bit_end) begin
                if (r_bit_idx == (r_bit8 ? 3'd7 : 3'd6)) begin
                    w_state_next = r_par_en ? ST_PARITY : ST_STOP1;
                end else begin
                    w_idx_next   = r_bit_idx + 3'd1;
                    w_shift_next = {1'b0, r_shift[7:1]};
                end
            end
            ST_PARITY: if (w_bit_end) w_state_next = ST_STOP1;
            ST_STOP1: if (w_bit_end) begin
`ifdef UART_TX_STOP2_EN
                if (r_stop2) w_state_next = ST_STOP2;
                else         w_frame_done = 1'b1;
`else
                w_frame_done = 1'b1;
`endif
            end
`ifdef UART_TX_STOP2_EN
            ST_STOP2: if (w_bit_end) w_frame_done = 1'b1;
`endif
            default: w_state_next = ST_IDLE;
        endcase

        // End of the last stop bit chains straight into the next start bit
        if (w_frame_done) begin
            w_state_next = ST_IDLE;
            w_pop        = ~w_empty;
        end
        if (w_pop) begin
            w_state_next = ST_START;
            w_baud_next  = w_div_m1;
            w_shift_next = w_head;
            w_idx_next   = 3'd0;
        end

        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = r_parity;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_bit8     <= 1'b1;
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
`ifdef UART_TX_STOP2_EN
            r_stop2    <= 1'b0;
`endif
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            if (w_pop) begin
                r_bit8   <= bit8;
                r_par_en <= parity_en;
                r_parity <= w_par;
`ifdef UART_TX_STOP2_EN
                r_stop2  <= stop2;
`endif
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

`ifdef UART_TX_STOP2_EN
    localparam bit c_stop2_en = 1'b1;
`else
    localparam bit c_stop2_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0, we = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0, stop2 = 1'b0;
    logic [15:0] divisor = 16'd1;
    logic        ovf_clr = 1'b0;
    logic        txrdy, tx, busy, overflow;
    logic [3:0]  fifo_count;

    int n_checks = 0;
    int n_err    = 0;
    bit exp_q[$];

    uart_tx_fifo #(.DEPTH(8), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .data(data),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .stop2(stop2), .divisor(divisor), .ovf_clr(ovf_clr),
        .txrdy(txrdy), .tx(tx), .busy(busy), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: list of line levels, each repeated for one bit period
    function automatic void build_frame(input logic [7:0] d, input bit b8, input bit pe,
                                        input bit od, input bit s2, input int dv);
        bit bits[$];
        int nb   = b8 ? 8 : 7;
        int per  = (dv == 0) ? 1 : dv;
        int ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) bits.push_back(od ? (ones % 2 == 0) : (ones % 2 == 1));
        bits.push_back(1'b1);
        if (s2 && c_stop2_en) bits.push_back(1'b1);
        foreach (bits[k]) repeat (per) exp_q.push_back(bits[k]);
    endfunction

    task automatic run_frame(input logic [7:0] d, input bit b8, input bit pe,
                             input bit od, input bit s2, input int dv);
        int len;
        @(negedge clk);
        data = d; bit8 = b8; parity_en = pe; odd_n_even = od; stop2 = s2;
        divisor = 16'(dv); cs = 1'b1; we = 1'b1;
        exp_q.delete();
        build_frame(d, b8, pe, od, s2, dv);
        len = exp_q.size();
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
        check("count_after_write", 32'(fifo_count), 1);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            check("tx_bit", 32'(tx), 32'(exp_q[i]));
            check("busy_in_frame", 32'(busy), 1);
            if (i == 0) check("count_after_pop", 32'(fifo_count), 0);
        end
        @(posedge clk); #1;
        check("tx_idle_after", 32'(tx), 1);
        check("busy_after", 32'(busy), 0);
    endtask

    initial begin
        int len;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_txrdy", 32'(txrdy), 1);
        check("rst_ovf", 32'(overflow), 0);
        @(negedge clk) reset = 1'b1;

        // Directed frames: parity odd/even, 7-bit, two stop bits, divisor 0
        run_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 4);
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        // Randomized frames
        for (int n = 0; n < 8; n++) begin
            run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), int'($urandom_range(0, 5)));
        end

        // Ten consecutive writes: nine accepted, back-to-back frames, overflow
        exp_q.delete();
        for (int w = 1; w <= 9; w++) build_frame(8'(w), 1'b1, 1'b0, 1'b0, 1'b0, 16);
        len = exp_q.size();
        for (int c = 0; c <= len + 1; c++) begin
            @(negedge clk);
            bit8 = 1'b1; parity_en = 1'b0; stop2 = 1'b0; divisor = 16'd16;
            cs = (c <= 10); we = (c <= 10);
            data = (c < 10) ? 8'(c + 1) : 8'hEE;
            ovf_clr = (c == 10 || c == 11);
            @(posedge clk); #1;
            if (c >= 1 && c <= len) begin
                check("b2b_tx", 32'(tx), 32'(exp_q[c-1]));
                check("b2b_busy", 32'(busy), 1);
            end
            if (c == 8) check("ovf_before_drop", 32'(overflow), 0);
            if (c == 9) begin
                check("ovf_set", 32'(overflow), 1);
                check("txrdy_full", 32'(txrdy), 0);
                check("count_full", 32'(fifo_count), 8);
            end
            if (c == 10) begin
                check("ovf_set_wins", 32'(overflow), 1);
                check("count_full_kept", 32'(fifo_count), 8);
            end
            if (c == 11) check("ovf_cleared", 32'(overflow), 0);
            if (c == len + 1) begin
                check("b2b_tx_end", 32'(tx), 1);
                check("b2b_busy_end", 32'(busy), 0);
                check("b2b_count_end", 32'(fifo_count), 0);
            end
        end

        // Asynchronous reset during DATA with three words queued
        @(negedge clk);
        divisor = 16'd4; bit8 = 1'b1; parity_en = 1'b0; stop2 = 1'b0;
        cs = 1'b1; we = 1'b1; data = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 1);
        check("pre_rst_count", 32'(fifo_count), 3);
        check("pre_rst_tx_data", 32'(tx), 0);
        #2 reset = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 1);
        check("arst_busy", 32'(busy), 0);
        check("arst_count", 32'(fifo_count), 0);
        check("arst_txrdy", 32'(txrdy), 1);
        check("arst_ovf", 32'(overflow), 0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check("post_rst_tx", 32'(tx), 1);
            check("post_rst_busy", 32'(busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO depth in words; power of two, minimum 2.
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the bit-period divisor.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cs, input, 1 bit: chip select, active-high.
REQ-006 SHALL have port we, input, 1 bit: write enable, active-high.
REQ-007 SHALL have port data, input, 8 bits: word to enqueue.
REQ-008 SHALL have port bit8, input, 1 bit: 1 = 8 data bits, 0 = 7 data bits (data[6:0]).
REQ-009 SHALL have port parity_en, input, 1 bit: 1 appends a parity bit.
REQ-010 SHALL have port odd_n_even, input, 1 bit: 1 = odd parity, 0 = even parity.
REQ-011 SHALL have port stop2, input, 1 bit: 1 = two stop bits (honoured only per REQ-032).
REQ-012 SHALL have port divisor, input, DIV_W bits: bit period in clocks; value 0 is treated as 1.
REQ-013 SHALL have port ovf_clr, input, 1 bit: synchronous clear of the overflow flag.
REQ-014 SHALL have port txrdy, output, 1 bit: FIFO not full.
REQ-015 SHALL have port tx, output, 1 bit: registered serial line, idle high.
REQ-016 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-017 SHALL have port fifo_count, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-018 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.

Function
REQ-019 SHALL push data on each rising edge where cs=1, we=1 and fifo_count<DEPTH; writes are level-based, one push per cycle while asserted.
REQ-020 SHALL drop a write when fifo_count=DEPTH; the dropped write sets overflow=1, and the FIFO contents are unchanged.
REQ-021 SHALL base acceptance on occupancy before the edge: a simultaneous pop does not make room for a write that cycle.
REQ-022 SHALL clear overflow when ovf_clr=1; if a clear and a drop coincide, the set wins.
REQ-023 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-024 SHALL pop in IDLE when the FIFO is non-empty, latching data, bit8, parity_en, odd_n_even and stop2 at the pop edge, and enter START; mid-frame input changes are ignored.
REQ-025 SHALL drive tx low from the pop edge, i.e. 1 clock after the write edge into an empty FIFO while IDLE.
REQ-026 SHALL hold every bit, including start, parity and stop, for exactly max(divisor,1) clocks, using a baud counter that reloads at each bit boundary.
REQ-027 SHALL send DATA LSB first, 8 or 7 bits, then go to PARITY if parity_en, else to STOP1.
REQ-028 SHALL compute the parity bit so that (data bits + parity) has an odd ones-count when odd_n_even=1, and an even ones-count when odd_n_even=0.
REQ-029 SHALL drive tx=1 in STOP1/STOP2; at the end of the last stop bit it pops directly into START if the FIFO is non-empty (back-to-back frames, no idle gap), else goes to IDLE.
REQ-030 SHALL assert busy in every state except IDLE; fifo_count SHALL update on the edge of each push or pop, and a simultaneous push and pop SHALL leave it unchanged.

Reset
REQ-031 SHALL, on reset=0 (asynchronous, including mid-frame), force tx=1, busy=0, overflow=0, fifo_count=0, txrdy=1 and state IDLE, and empty the FIFO; operation resumes on the first edge after release.

Configuration
REQ-032 SHALL, with macro UART_TX_STOP2_EN defined, honour stop2 (STOP1 -> STOP2 when latched stop2=1); without the macro, the stop2 port exists but is ignored, the STOP2 state is not built and every frame has one stop bit.

Verification
REQ-033 SHALL cover: divisor=4, bit8=1, parity_en=1, odd=1, one write of 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1,1, each bit 4 clocks, 44 clocks total, busy=0 afterwards.
REQ-034 SHALL cover: same setup with odd_n_even=0 -> parity bit 0; bit8=0, parity_en=0, data 0x5A -> start, 0,1,0,1,1,0,1, stop, 36 clocks.
REQ-035 SHALL cover: DEPTH=8, divisor=16, 10 writes on consecutive cycles -> words 1-9 accepted, 10th dropped, overflow=1, txrdy=0, and the 9 frames are back-to-back with no idle gap.
REQ-036 SHALL cover: reset=0 in the middle of the DATA state with 3 words queued -> tx=1 immediately, fifo_count=0, busy=0, and no further frames.
REQ-037 SHALL cover: UART_TX_STOP2_EN defined, stop2=1, divisor=2 -> two high stop bits, 4 clocks; without the macro -> 2 clocks.
REQ-038 SHALL cover: divisor=0 -> every bit lasts 1 clock.
